fpa_controller: RTL and testbench

FPA_CONTROLLER -- requirements
Module: fpa_controller

---
 rtl/fpa_controller_if.sv | 39 +++
 rtl/fpa_controller.sv | 150 +++++++++++++++
 tb/tb_fpa_controller.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/fpa_controller_if.sv
// Handshake and strobe bundle between the FP-add controller and its datapath.
// master = controller (drives strobes), slave = datapath (drives status flags).
interface fpa_controller_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             exp_lt;
    logic [CNT_W-1:0] exp_diff;
    logic             cnt_complete;
    logic             sum_zero;
    logic             sum_ovf;
    logic             mant_msb;

    logic             busy;
    logic             done;
    logic             ld_ops;
    logic             swap;
    logic             ld_cnt;
    logic             cnt_en;
    logic             flush_small;
    logic             sh_align;
    logic             ld_sum;
    logic             sh_norm_r;
    logic             sh_norm_l;
    logic             rnd_add;
    logic             ld_res;

    modport master (
        input  start, exp_lt, exp_diff, cnt_complete, sum_zero, sum_ovf, mant_msb,
        output busy, done, ld_ops, swap, ld_cnt, cnt_en, flush_small, sh_align,
               ld_sum, sh_norm_r, sh_norm_l, rnd_add, ld_res
    );

    modport slave (
        output start, exp_lt, exp_diff, cnt_complete, sum_zero, sum_ovf, mant_msb,
        input  busy, done, ld_ops, swap, ld_cnt, cnt_en, flush_small, sh_align,
               ld_sum, sh_norm_r, sh_norm_l, rnd_add, ld_res
    );
endinterface

// File: rtl/fpa_controller.sv
// Sequencing FSM for a floating-point adder: load, compare, align, add, normalise, done.
// Define FPA_CTRL_ROUND_EN to add a single rounding pass followed by renormalisation.
module fpa_controller #(
    parameter int CNT_W     = 8,
    parameter int MAX_SHIFT = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    fpa_controller_if.master     bus
);

    localparam logic [CNT_W-1:0] MAX_SHIFT_C = CNT_W'(MAX_SHIFT);

`ifdef FPA_CTRL_ROUND_EN
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CMP, S_ALIGN, S_ADD, S_NORM, S_ROUND, S_DONE
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CMP, S_ALIGN, S_ADD, S_NORM, S_DONE
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] norm_cnt_q, norm_cnt_d;
`ifdef FPA_CTRL_ROUND_EN
    logic             rnd_done_q, rnd_done_d;
`endif

    logic done_o, ld_ops_o, swap_o, ld_cnt_o, cnt_en_o, flush_small_o, sh_align_o;
    logic ld_sum_o, sh_norm_r_o, sh_norm_l_o, rnd_add_o, ld_res_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            norm_cnt_q <= '0;
`ifdef FPA_CTRL_ROUND_EN
            rnd_done_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            norm_cnt_q <= norm_cnt_d;
`ifdef FPA_CTRL_ROUND_EN
            rnd_done_q <= rnd_done_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        norm_cnt_d    = norm_cnt_q;
`ifdef FPA_CTRL_ROUND_EN
        rnd_done_d    = rnd_done_q;
`endif
        done_o        = 1'b0;
        ld_ops_o      = 1'b0;
        swap_o        = 1'b0;
        ld_cnt_o      = 1'b0;
        cnt_en_o      = 1'b0;
        flush_small_o = 1'b0;
        sh_align_o    = 1'b0;
        ld_sum_o      = 1'b0;
        sh_norm_r_o   = 1'b0;
        sh_norm_l_o   = 1'b0;
        rnd_add_o     = 1'b0;
        ld_res_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) state_d = S_LOAD;
            end
            S_LOAD: begin
                ld_ops_o = 1'b1;
                state_d  = S_CMP;
            end
            S_CMP: begin
                swap_o   = bus.exp_lt;
                ld_cnt_o = 1'b1;
                if (bus.exp_diff == '0) begin
                    state_d = S_ADD;
                end else if (bus.exp_diff >= MAX_SHIFT_C) begin
                    // Smaller operand is shifted out entirely; skip alignment.
                    flush_small_o = 1'b1;
                    state_d       = S_ADD;
                end else begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                // Shift on the completing cycle too, so exactly exp_diff shifts occur.
                sh_align_o = 1'b1;
                cnt_en_o   = 1'b1;
                if (bus.cnt_complete) state_d = S_ADD;
            end
            S_ADD: begin
                ld_sum_o   = 1'b1;
                norm_cnt_d = '0;
`ifdef FPA_CTRL_ROUND_EN
                rnd_done_d = 1'b0;
`endif
                state_d    = S_NORM;
            end
            S_NORM: begin
                if (bus.sum_zero) begin
                    state_d = S_DONE;
                end else if (bus.sum_ovf) begin
                    sh_norm_r_o = 1'b1;
                end else if (!bus.mant_msb && (norm_cnt_q < MAX_SHIFT_C)) begin
                    sh_norm_l_o = 1'b1;
                    norm_cnt_d  = norm_cnt_q + CNT_W'(1);
                end else begin
`ifdef FPA_CTRL_ROUND_EN
                    state_d = rnd_done_q ? S_DONE : S_ROUND;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef FPA_CTRL_ROUND_EN
            S_ROUND: begin
                // Rounding can carry out, so the result goes back through NORM once.
                rnd_add_o  = 1'b1;
                rnd_done_d = 1'b1;
                state_d    = S_NORM;
            end
`endif
            S_DONE: begin
                ld_res_o = 1'b1;
                done_o   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy        = (state_q != S_IDLE);
    assign bus.done        = done_o;
    assign bus.ld_ops      = ld_ops_o;
    assign bus.swap        = swap_o;
    assign bus.ld_cnt      = ld_cnt_o;
    assign bus.cnt_en      = cnt_en_o;
    assign bus.flush_small = flush_small_o;
    assign bus.sh_align    = sh_align_o;
    assign bus.ld_sum      = ld_sum_o;
    assign bus.sh_norm_r   = sh_norm_r_o;
    assign bus.sh_norm_l   = sh_norm_l_o;
    assign bus.rnd_add     = rnd_add_o;
    assign bus.ld_res      = ld_res_o;

endmodule

// File: tb/tb_fpa_controller.sv
// Scoreboard bench for fpa_controller: directed operations, monitor compares strobe counts per done pulse.
module tb_fpa_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fpa_controller_if #(.CNT_W(8)) bus ();

    fpa_controller #(.CNT_W(8), .MAX_SHIFT(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

`ifdef FPA_CTRL_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Datapath model: alignment down-counter, overflow flag, leading-zero distance
    logic [7:0] cnt_q;
    logic       ovf_q;
    int         lz_q;
    logic       ovf_init;
    int         lz_init;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
            lz_q  <= 0;
        end else begin
            if (bus.ld_cnt) cnt_q <= bus.exp_diff;
            else if (bus.cnt_en && cnt_q != 0) cnt_q <= cnt_q - 8'd1;
            if (bus.ld_sum) ovf_q <= ovf_init;
            else if (bus.sh_norm_r) ovf_q <= 1'b0;
            if (bus.ld_sum) lz_q <= lz_init;
            else if (bus.sh_norm_l && lz_q > 0) lz_q <= lz_q - 1;
        end
    end

    assign bus.cnt_complete = (cnt_q <= 8'd1);
    assign bus.sum_ovf      = ovf_q;
    assign bus.mant_msb     = (lz_q == 0);

    function automatic int outs();
        return int'({bus.busy, bus.done, bus.ld_ops, bus.swap, bus.ld_cnt, bus.cnt_en,
                     bus.flush_small, bus.sh_align, bus.ld_sum, bus.sh_norm_r,
                     bus.sh_norm_l, bus.rnd_add, bus.ld_res});
    endfunction

    typedef struct {
        int cyc; int swap; int flush; int align; int nr; int nl; int rnd;
    } exp_t;

    typedef struct {
        int diff; int lt; int ovf; int lz; int zero;
        int swap; int flush; int align; int nr; int nl; int cyc;
        int poke_busy; int poke_done;
    } vec_t;

    exp_t q[$];

    // Monitor: accumulate strobes over one busy window, compare on done
    int a_cyc, a_ld_ops, a_swap, a_ld_cnt, a_cnt_en, a_flush, a_align;
    int a_ld_sum, a_nr, a_nl, a_rnd, a_ld_res;

    task automatic clr_acc();
        a_cyc = 0; a_ld_ops = 0; a_swap = 0; a_ld_cnt = 0; a_cnt_en = 0; a_flush = 0;
        a_align = 0; a_ld_sum = 0; a_nr = 0; a_nl = 0; a_rnd = 0; a_ld_res = 0;
    endtask

    initial clr_acc();

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            clr_acc();
        end else if (bus.busy === 1'b1) begin
            a_cyc++;
            a_ld_ops += int'(bus.ld_ops);
            a_swap   += int'(bus.swap);
            a_ld_cnt += int'(bus.ld_cnt);
            a_cnt_en += int'(bus.cnt_en);
            a_flush  += int'(bus.flush_small);
            a_align  += int'(bus.sh_align);
            a_ld_sum += int'(bus.ld_sum);
            a_nr     += int'(bus.sh_norm_r);
            a_nl     += int'(bus.sh_norm_l);
            a_rnd    += int'(bus.rnd_add);
            a_ld_res += int'(bus.ld_res);
            if (bus.done) begin
                if (q.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("latency", a_cyc, e.cyc);
                    chk("ld_ops", a_ld_ops, 1);
                    chk("swap", a_swap, e.swap);
                    chk("ld_cnt", a_ld_cnt, 1);
                    chk("flush_small", a_flush, e.flush);
                    chk("sh_align", a_align, e.align);
                    chk("cnt_en", a_cnt_en, e.align);
                    chk("ld_sum", a_ld_sum, 1);
                    chk("sh_norm_r", a_nr, e.nr);
                    chk("sh_norm_l", a_nl, e.nl);
                    chk("rnd_add", a_rnd, e.rnd);
                    chk("ld_res", a_ld_res, 1);
                end
                clr_acc();
            end
        end else begin
            chk("idle_outputs", outs(), 0);
        end
    end

    task automatic run_op(input vec_t v);
        exp_t e;
        int   n;
        bit   fin;
        e.cyc   = v.cyc + ((v.zero != 0) ? 0 : 2 * RND);
        e.swap  = v.swap;
        e.flush = v.flush;
        e.align = v.align;
        e.nr    = v.nr;
        e.nl    = v.nl;
        e.rnd   = (v.zero != 0) ? 0 : RND;
        @(negedge clk);
        bus.exp_diff = v.diff[7:0];
        bus.exp_lt   = v.lt[0];
        bus.sum_zero = v.zero[0];
        ovf_init     = v.ovf[0];
        lz_init      = v.lz;
        q.push_back(e);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        n   = 0;
        fin = 1'b0;
        for (int i = 0; i < 200 && !fin; i++) begin
            if (i == v.poke_busy) bus.start = 1'b1;
            if (bus.done && v.poke_done != 0) bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            n++;
            if (!bus.busy) fin = 1'b1;
        end
        if (!fin) chk("op_timeout", 0, 1);
        else chk("busy_cycles", n, e.cyc);
    endtask

    vec_t vecs[9];

    initial begin
        int   k;
        bit   seen;
        vec_t v;
        bus.start    = 1'b0;
        bus.exp_lt   = 1'b0;
        bus.exp_diff = '0;
        bus.sum_zero = 1'b0;
        ovf_init     = 1'b0;
        lz_init      = 0;

        //          diff lt ovf lz zero | swap flush align nr nl cyc | poke_busy poke_done
        vecs[0] = '{3,  1, 0, 0,  0,  1, 0, 3,  0, 0,  8,  -1, 0};
        vecs[1] = '{0,  0, 1, 0,  0,  0, 0, 0,  1, 0,  6,  -1, 1};
        vecs[2] = '{30, 0, 0, 0,  0,  0, 1, 0,  0, 0,  5,  -1, 0};
        vecs[3] = '{0,  0, 0, 63, 0,  0, 0, 0,  0, 24, 29,  5, 0};
        vecs[4] = '{5,  1, 0, 63, 1,  1, 0, 5,  0, 0,  10, -1, 0};
        vecs[5] = '{24, 1, 0, 2,  0,  1, 1, 0,  0, 2,  7,  -1, 0};
        vecs[6] = '{23, 0, 1, 0,  0,  0, 0, 23, 1, 0,  29,  2, 0};
        vecs[7] = '{1,  0, 1, 3,  0,  0, 0, 1,  1, 3,  10, -1, 0};
        vecs[8] = '{2,  1, 0, 0,  0,  1, 0, 2,  0, 0,  7,  -1, 1};

        #2 rst = 1'b1;
        #1 chk("reset_outputs", outs(), 0);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_op(vecs[i]);

        // Abort mid-alignment with a reset pulse
        @(negedge clk);
        bus.exp_diff = 8'd10;
        bus.exp_lt   = 1'b0;
        bus.sum_zero = 1'b0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (bus.sh_align) seen = 1'b1;
        end
        chk("reached_align", int'(seen), 1);
        repeat (2) @(negedge clk);
        #3 rst = 1'b1;
        #1 chk("abort_outputs", outs(), 0);
        chk("abort_busy", int'(bus.busy), 0);
        @(negedge clk);
        #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_idle", int'(bus.busy), 0);

        run_op(vecs[8]);

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
